// File: rtl/ysyx_24080014_pkg.sv
// rtl/ysyx_24080014_pkg.sv - shared types and constants for the LSU AXI4-lite master
package ysyx_24080014_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_BRESP = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Half needs even address, word (and size code 3) needs 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// rtl/ysyx_24080014_lsu_align.sv - store lane/strobe generation and load extract/extend
module ysyx_24080014_lsu_align
    import ysyx_24080014_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_lanes,
    output logic [3:0]  o_st_strb,
    input  logic [31:0] i_ld_data,
    output logic [31:0] o_ld_data
);

    logic [4:0]  w_shamt;
    logic [3:0]  w_base_mask;
    logic [31:0] w_ld_shift;

    assign w_shamt    = {i_addr_lo, 3'b000};
    assign o_st_lanes = i_st_data << w_shamt;
    // Lanes shifted past byte 3 are simply dropped by the 4-bit result.
    assign o_st_strb  = w_base_mask << i_addr_lo;
    assign w_ld_shift = i_ld_data >> w_shamt;

    // Base strobe mask by access size before lane shifting.
    always_comb begin
        case (i_size)
            SIZE_B:  w_base_mask = 4'b0001;
            SIZE_H:  w_base_mask = 4'b0011;
            default: w_base_mask = 4'b1111;
        endcase
    end

    // Select byte/half/word from the shifted read data and extend it.
    always_comb begin
        case (i_size)
            SIZE_B:  o_ld_data = i_unsigned ? {24'h000000, w_ld_shift[7:0]}
                                            : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            SIZE_H:  o_ld_data = i_unsigned ? {16'h0000, w_ld_shift[15:0]}
                                            : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: o_ld_data = w_ld_shift;
        endcase
    end

endmodule

// File: rtl/ysyx_24080014_lsu_axi_master.sv
// rtl/ysyx_24080014_lsu_axi_master.sv - LSU to AXI4-lite master, optional YSYX_24080014_LSU_MISALIGN_CHECK_EN
module ysyx_24080014_lsu_axi_master
    import ysyx_24080014_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic              o_wvalid,
    input  logic              i_wready,
    output logic [DATA_W-1:0] o_wdata,
    output logic [7:0]        o_wstrb,
    input  logic              i_bvalid,
    output logic              o_bready,
    input  logic [1:0]        i_bresp,
    output logic              o_arvalid,
    input  logic              i_arready,
    output logic [ADDR_W-1:0] o_araddr,
    input  logic              i_rvalid,
    output logic              o_rready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp
);

    lsu_state_t        r_state;
    logic [1:0]        r_addr_lo;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic              r_awvalid;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_wvalid;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wstrb;
    logic              r_bready;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_rready;

    logic [1:0]        w_sel_addr_lo;
    logic [1:0]        w_sel_size;
    logic [DATA_W-1:0] w_st_lanes;
    logic [3:0]        w_st_strb;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_aw_done;
    logic              w_w_done;

    // In IDLE the aligner sees the incoming request (store lanes are latched
    // at acceptance); afterwards it sees the latched request for load extract.
    assign w_sel_addr_lo = (r_state == ST_IDLE) ? i_req_addr[1:0] : r_addr_lo;
    assign w_sel_size    = (r_state == ST_IDLE) ? i_req_size      : r_size;

    assign w_aw_done = !r_awvalid || i_awready;
    assign w_w_done  = !r_wvalid  || i_wready;

    ysyx_24080014_lsu_align u_align (
        .i_addr_lo  (w_sel_addr_lo),
        .i_size     (w_sel_size),
        .i_unsigned (r_unsigned),
        .i_st_data  (i_req_wdata),
        .o_st_lanes (w_st_lanes),
        .o_st_strb  (w_st_strb),
        .i_ld_data  (i_rdata),
        .o_ld_data  (w_ld_data)
    );

    // Transaction FSM with all bus and core-facing outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_addr_lo    <= 2'b00;
            r_size       <= SIZE_B;
            r_unsigned   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_awvalid    <= 1'b0;
            r_awaddr     <= '0;
            r_wvalid     <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= 8'h00;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_rready     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_addr_lo   <= i_req_addr[1:0];
                        r_size      <= i_req_size;
                        r_unsigned  <= i_req_unsigned;
`ifdef YSYX_24080014_LSU_MISALIGN_CHECK_EN
                        if (is_misaligned(i_req_addr[1:0], i_req_size)) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                        end else
`endif
                        if (i_req_wen) begin
                            r_state   <= ST_WADDR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_bready  <= 1'b1;
                            r_awaddr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
                            r_wdata   <= w_st_lanes;
                            r_wstrb   <= {4'b0000, w_st_strb};
                        end else begin
                            r_state   <= ST_RADDR;
                            r_arvalid <= 1'b1;
                            r_rready  <= 1'b1;
                            r_araddr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                ST_RADDR: begin
                    if (i_arready) begin
                        r_arvalid <= 1'b0;
                        if (i_rvalid) begin
                            r_rready     <= 1'b0;
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_ld_data;
                            r_resp_err   <= (i_rresp != AXI_RESP_OKAY);
                        end else begin
                            r_state <= ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (i_rvalid) begin
                        r_rready     <= 1'b0;
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_ld_data;
                        r_resp_err   <= (i_rresp != AXI_RESP_OKAY);
                    end
                end
                ST_WADDR: begin
                    if (r_awvalid && i_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        if (i_bvalid) begin
                            r_bready     <= 1'b0;
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_err   <= (i_bresp != AXI_RESP_OKAY);
                        end else begin
                            r_state <= ST_BRESP;
                        end
                    end
                end
                ST_BRESP: begin
                    if (i_bvalid) begin
                        r_bready     <= 1'b0;
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_resp_err   <= (i_bresp != AXI_RESP_OKAY);
                    end
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_awvalid    = r_awvalid;
    assign o_awaddr     = r_awaddr;
    assign o_wvalid     = r_wvalid;
    assign o_wdata      = r_wdata;
    assign o_wstrb      = r_wstrb;
    assign o_bready     = r_bready;
    assign o_arvalid    = r_arvalid;
    assign o_araddr     = r_araddr;
    assign o_rready     = r_rready;

endmodule
